time_keeper: RTL and testbench
==============================

// Module: time_keeper
// PURPOSE
//   Timekeeping core of the digital clock. It divides clk down to a 1 Hz advance and keeps
//   24-hour hour/min/sec binary counters. A two-button setting state machine lets the user
//   set the time. hour/min/sec drive the display scanner directly, which is downstream.
// PARAMETERS
//   TICK_DIV  50_000_000  clk cycles per second; benches override with a small value (e.g. 4)
//   CNT_W     26          prescaler width, must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//   clk       in   1  system clock
//   rst       in   1  reset, asynchronous, active-high
//   btn_mode  in   1  debounced single-cycle pulse: step the setting mode
//   btn_inc   in   1  debounced single-cycle pulse: increment the field being set
//   hour      out  5  hours, 0..23, registered
//   min       out  6  minutes, 0..59, registered
//   sec       out  6  seconds, 0..59, registered
//   set_mode  out  2  00=RUN, 01=SET_HOUR, 10=SET_MIN; 11 never driven
//   sec_tick  out  1  one-cycle pulse on each cycle where sec advances in RUN
//   chime     out  1  one-cycle hourly pulse (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: hour=0, min=0, sec=0, set_mode=RUN, prescaler=0, sec_tick=0, chime=0.
// - Prescaler, RUN only:
//   - counts 0..TICK_DIV-1 and wraps to 0;
//   - tick = (prescaler == TICK_DIV-1);
//   - the first tick after reset comes TICK_DIV cycles after rst deasserts.
//   - In SET_* states the prescaler is held at 0.
// - Advance on tick, applied at the same clock edge:
//   - sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0.
//   - sec_tick goes high for the cycle following that edge, aligned with the new sec value.
// - FSM, stepped by btn_mode: RUN -> SET_HOUR -> SET_MIN -> RUN.
// - SET_HOUR: btn_inc increments hour, 23->0, no carry. min and sec are frozen.
// - SET_MIN: btn_inc increments min, 59->0, no carry into hour. hour and sec are frozen.
// - SET_MIN -> RUN: sec is cleared to 0 and the prescaler restarts from 0. The next tick
//   comes TICK_DIV cycles later.
// - Entering SET_HOUR from RUN: a tick on the same cycle is discarded and the time is not
//   advanced.
// - btn_mode and btn_inc in the same cycle: btn_mode wins and btn_inc is ignored.
// - btn_inc in RUN: ignored.
// - sec_tick is never asserted outside RUN.
// - Field values can never leave their legal ranges.
// - rst asserted mid-operation (including mid-setting) returns all state to the reset values
//   immediately, without waiting for a clock edge.
// CONFIGURATION
//   `define CHIME_EN
//   - Defined: chime pulses for exactly one cycle after a RUN tick that rolls min:sec from
//     59:59 to 00:00. It is coincident with sec_tick.
//   - Setting the time through SET_MIN never produces a chime.
//   - Not defined: chime is a constant 0 and the chime logic is not synthesised. The port
//     is present either way.
// TESTING  (TICK_DIV=4)
//   1. Release rst, idle 4 cycles: sec_tick pulses once and sec=1. After 240 cycles, min=1, sec=0.
//   2. Force the time to 23:59:58 (via set, then run), run 2 ticks: the display reads 00:00:00,
//      and chime=1 on the second tick only with CHIME_EN (0 without).
//   3. mode, then 25 inc pulses: set_mode=01 and hour=1 (wrap at 24); min/sec unchanged and
//      no sec_tick while setting.
//   4. mode, mode, then 61 inc pulses: min=1 and hour unchanged. Then mode: set_mode=00,
//      sec=0, and the next sec_tick comes 4 cycles later.
//   5. btn_mode and btn_inc pulsed in the same cycle from RUN: set_mode=01 and hour unchanged.
//   6. Assert rst asynchronously mid-cycle while in SET_MIN: outputs go to 0/RUN immediately;
//      after release, behaviour matches test 1.

Source files
------------

// File: rtl/time_keeper.sv
// 24-hour timekeeping core: 1 Hz prescaler, hour/min/sec counters and a two-button setting FSM.
// Define CHIME_EN to build the hourly chime pulse; otherwise chime is tied to 0.
module time_keeper #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] set_mode,
    output logic       sec_tick,
    output logic       chime
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_e;

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

    mode_e            state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [4:0]       hour_q, hour_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic             sec_tick_q;
    logic             tick;
    logic             advance;

    assign tick    = (state_q == RUN) && (presc_q == PRESC_MAX);
    // A mode press on a tick cycle leaves RUN, so that tick never advances the time.
    assign advance = tick && !btn_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            presc_q    <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            sec_tick_q <= advance;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        case (state_q)
            RUN: begin
                if (btn_mode) begin
                    state_d = SET_HOUR;
                    presc_d = '0;
                end else if (tick) begin
                    presc_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d  = '0;
                            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            SET_HOUR: begin
                presc_d = '0;
                if (btn_mode) begin
                    state_d = SET_MIN;
                end else if (btn_inc) begin
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end
            end
            SET_MIN: begin
                presc_d = '0;
                if (btn_mode) begin
                    state_d = RUN;
                    sec_d   = '0;
                end else if (btn_inc) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            default: begin
                state_d = RUN;
                presc_d = '0;
            end
        endcase
    end

`ifdef CHIME_EN
    logic chime_q;
    logic rollover;

    assign rollover = (min_q == 6'd59) && (sec_q == 6'd59);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chime_q <= 1'b0;
        end else begin
            chime_q <= advance && rollover;
        end
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

    assign hour     = hour_q;
    assign min      = min_q;
    assign sec      = sec_q;
    assign set_mode = state_q;
    assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV=4: a vector table for the setting FSM plus
// hand-written sequences for reset, rollover/chime and asynchronous reset.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] set_mode;
    logic       sec_tick;
    logic       chime;

    int total = 0;
    int bad   = 0;

`ifdef CHIME_EN
    localparam int CHIME_EXP = 1;
`else
    localparam int CHIME_EXP = 0;
`endif

    time_keeper #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .hour    (hour),
        .min     (min),
        .sec     (sec),
        .set_mode(set_mode),
        .sec_tick(sec_tick),
        .chime   (chime)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic       i;
        logic [4:0] h;
        logic [5:0] mi;
        logic [5:0] s;
        logic [1:0] sm;
        logic       t;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic m, input logic i, input int h, input int mi,
                                input int s, input int sm, input logic t);
        vec_t v;
        v.m  = m;
        v.i  = i;
        v.h  = 5'(h);
        v.mi = 6'(mi);
        v.s  = 6'(s);
        v.sm = 2'(sm);
        v.t  = t;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of button inputs, then sample 1 time unit after the edge.
    task automatic step(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic check_boot(input string tag);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b0);
            chk({tag, "_pre_tick"}, sec_tick, 0);
        end
        step(1'b0, 1'b0);
        chk({tag, "_first_tick"}, sec_tick, 1);
        chk({tag, "_first_sec"}, sec, 1);
        chk({tag, "_first_mode"}, set_mode, 0);
    endtask

    initial begin
        int n_tick;
        int n_chime;

        // Vector table, starting from 00:01:00 in RUN with the prescaler just wrapped.
        add(1, 0, 0, 1, 0, 1, 0);
        for (int k = 1; k <= 25; k++) add(0, 1, k % 24, 1, 0, 1, 0);
        add(1, 0, 1, 1, 0, 2, 0);
        for (int k = 1; k <= 61; k++) add(0, 1, 1, (1 + k) % 60, 0, 2, 0);
        add(1, 0, 1, 2, 0, 0, 0);
        add(0, 1, 1, 2, 0, 0, 0);
        add(0, 0, 1, 2, 0, 0, 0);
        add(0, 0, 1, 2, 0, 0, 0);
        add(0, 0, 1, 2, 1, 0, 1);
        add(0, 0, 1, 2, 1, 0, 0);
        add(1, 1, 1, 2, 1, 1, 0);
        add(1, 1, 1, 2, 1, 2, 0);
        add(0, 1, 1, 3, 1, 2, 0);
        add(1, 0, 1, 3, 0, 0, 0);
        add(0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 1, 3, 0, 0, 0);
        add(1, 0, 1, 3, 0, 1, 0);
        add(1, 0, 1, 3, 0, 2, 0);
        add(1, 0, 1, 3, 0, 0, 0);
        add(1, 0, 1, 3, 0, 1, 0);
        for (int k = 1; k <= 22; k++) add(0, 1, 1 + k, 3, 0, 1, 0);
        add(1, 0, 23, 3, 0, 2, 0);
        for (int k = 1; k <= 56; k++) add(0, 1, 23, 3 + k, 0, 2, 0);
        add(1, 0, 23, 59, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hour", hour, 0);
        chk("rst_min", min, 0);
        chk("rst_sec", sec, 0);
        chk("rst_mode", set_mode, 0);
        chk("rst_tick", sec_tick, 0);
        chk("rst_chime", chime, 0);
        rst = 1'b0;

        // First tick TICK_DIV cycles after release, then one minute at cycle 240
        check_boot("boot");
        step(1'b0, 1'b0);
        chk("boot_tick_pulse", sec_tick, 0);
        for (int k = 6; k <= 240; k++) step(1'b0, 1'b0);
        chk("minute_min", min, 1);
        chk("minute_sec", sec, 0);
        chk("minute_hour", hour, 0);
        chk("minute_tick", sec_tick, 1);

        foreach (vecs[n]) begin
            step(vecs[n].m, vecs[n].i);
            chk($sformatf("vec%0d_hour", n), hour, vecs[n].h);
            chk($sformatf("vec%0d_min", n), min, vecs[n].mi);
            chk($sformatf("vec%0d_sec", n), sec, vecs[n].s);
            chk($sformatf("vec%0d_mode", n), set_mode, vecs[n].sm);
            chk($sformatf("vec%0d_tick", n), sec_tick, vecs[n].t);
            chk($sformatf("vec%0d_chime", n), chime, 0);
        end

        // Run 23:59:00 up to 23:59:58, then across midnight
        n_tick  = 0;
        n_chime = 0;
        for (int k = 0; k < 232; k++) begin
            step(1'b0, 1'b0);
            n_tick  += int'(sec_tick);
            n_chime += int'(chime);
        end
        chk("run58_ticks", n_tick, 58);
        chk("run58_chimes", n_chime, 0);
        chk("run58_hour", hour, 23);
        chk("run58_min", min, 59);
        chk("run58_sec", sec, 58);
        repeat (4) step(1'b0, 1'b0);
        chk("s59_sec", sec, 59);
        chk("s59_tick", sec_tick, 1);
        chk("s59_chime", chime, 0);
        repeat (3) begin
            step(1'b0, 1'b0);
            chk("mid_chime", chime, 0);
        end
        step(1'b0, 1'b0);
        chk("midnight_hour", hour, 0);
        chk("midnight_min", min, 0);
        chk("midnight_sec", sec, 0);
        chk("midnight_tick", sec_tick, 1);
        chk("midnight_chime", chime, CHIME_EXP);
        step(1'b0, 1'b0);
        chk("after_chime", chime, 0);
        chk("after_tick", sec_tick, 0);

        // Asynchronous reset while in SET_MIN
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("pre_arst_hour", hour, 1);
        chk("pre_arst_min", min, 1);
        chk("pre_arst_mode", set_mode, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hour", hour, 0);
        chk("arst_min", min, 0);
        chk("arst_sec", sec, 0);
        chk("arst_mode", set_mode, 0);
        chk("arst_tick", sec_tick, 0);
        chk("arst_chime", chime, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_boot("reboot");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
